// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/writeback selectors, immediate formats.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_PASS = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  // Assemble the sign-extended immediate for the given instruction format.
  function automatic logic signed [31:0] gen_imm(input logic [31:0] inst, input imm_type_e t);
    logic signed [31:0] imm;
    case (t)
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = {{20{inst[31]}}, inst[31:20]};
    endcase
    return imm;
  endfunction

  // Map funct3/funct7[5] onto an ALU operation; SUB only exists for register-register ops.
  function automatic alu_op_e alu_op_from_funct(input logic [2:0] f3, input logic f7b5,
                                                input logic is_reg);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: two combinational read ports with write-through bypass,
// one synchronous write port; x0 is hardwired to zero.
module regfile
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  input  logic                  we,
  input  logic [4:0]            rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data
);

  logic [DATA_WIDTH-1:0] mem [REG_COUNT];
  logic                  wr_en;

  assign wr_en = we && (rd_addr != 5'd0);

  // Write port: cleared on reset, x0 never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[rd_addr] <= rd_data;
    end
  end

  // Read ports: x0 reads zero, a same-cycle write to the addressed register is forwarded.
  always_comb begin
    rs1_data = mem[rs1_addr];
    rs2_data = mem[rs2_addr];
    if (rs1_addr == 5'd0)                          rs1_data = '0;
    else if (wr_en && (rd_addr == rs1_addr))       rs1_data = rd_data;
    if (rs2_addr == 5'd0)                          rs2_data = '0;
    else if (wr_en && (rd_addr == rs2_addr))       rs2_data = rd_data;
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction decode stage: field extraction, immediate generation, control
// decode, operand read, and the ID/EX pipeline register.
module id_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [31:0]           inst_i,
  input  logic [31:0]           pc_i,
  input  logic [31:0]           pc_plus4_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  wb_we_i,
  input  logic [4:0]            wb_rd_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  valid_o,
  output logic [31:0]           pc_o,
  output logic [31:0]           pc_plus4_o,
  output logic [4:0]            rs1_o,
  output logic [4:0]            rs2_o,
  output logic [4:0]            rd_o,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  output logic [31:0]           imm_o,
  output logic [3:0]            alu_op_o,
  output logic                  alu_src_o,
  output logic                  reg_we_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic                  branch_o,
  output logic                  jump_o,
  output logic [1:0]            wb_sel_o,
  output logic                  illegal_o
);

  logic [6:0]            opcode_p0;
  imm_type_e             imm_type_p0;
  logic signed [31:0]    imm_p0;
  alu_op_e               alu_op_p0;
  wb_sel_e               wb_sel_p0;
  logic                  alu_src_p0, reg_we_p0, mem_re_p0, mem_we_p0, branch_p0, jump_p0;
  logic                  known_p0;
  logic [DATA_WIDTH-1:0] rs1_data_p0, rs2_data_p0;

  assign opcode_p0 = inst_i[6:0];
  assign imm_p0    = gen_imm(inst_i, imm_type_p0);

  regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_COUNT  (REG_COUNT)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (inst_i[19:15]),
    .rs2_addr (inst_i[24:20]),
    .we       (wb_we_i),
    .rd_addr  (wb_rd_i),
    .rd_data  (wb_data_i),
    .rs1_data (rs1_data_p0),
    .rs2_data (rs2_data_p0)
  );

  // Opcode decode into immediate format and raw (ungated) control bits.
  always_comb begin
    imm_type_p0 = IMM_I;
    alu_op_p0   = ALU_ADD;
    wb_sel_p0   = WB_ALU;
    alu_src_p0  = 1'b0;
    reg_we_p0   = 1'b0;
    mem_re_p0   = 1'b0;
    mem_we_p0   = 1'b0;
    branch_p0   = 1'b0;
    jump_p0     = 1'b0;
    known_p0    = 1'b1;
    case (opcode_p0)
      OPC_LUI: begin
        imm_type_p0 = IMM_U; alu_op_p0 = ALU_PASS; alu_src_p0 = 1'b1; reg_we_p0 = 1'b1;
      end
      OPC_AUIPC: begin
        imm_type_p0 = IMM_U; alu_src_p0 = 1'b1; reg_we_p0 = 1'b1;
      end
      OPC_JAL: begin
        imm_type_p0 = IMM_J; alu_src_p0 = 1'b1; reg_we_p0 = 1'b1; jump_p0 = 1'b1;
        wb_sel_p0 = WB_PC4;
      end
      OPC_JALR: begin
        alu_src_p0 = 1'b1; reg_we_p0 = 1'b1; jump_p0 = 1'b1; wb_sel_p0 = WB_PC4;
      end
      OPC_BRANCH: begin
        imm_type_p0 = IMM_B; alu_op_p0 = ALU_SUB; branch_p0 = 1'b1;
      end
      OPC_LOAD: begin
        alu_src_p0 = 1'b1; reg_we_p0 = 1'b1; mem_re_p0 = 1'b1; wb_sel_p0 = WB_MEM;
      end
      OPC_STORE: begin
        imm_type_p0 = IMM_S; alu_src_p0 = 1'b1; mem_we_p0 = 1'b1;
      end
      OPC_OP_IMM: begin
        alu_op_p0 = alu_op_from_funct(inst_i[14:12], inst_i[30], 1'b0);
        alu_src_p0 = 1'b1; reg_we_p0 = 1'b1;
      end
      OPC_OP: begin
        alu_op_p0 = alu_op_from_funct(inst_i[14:12], inst_i[30], 1'b1);
        reg_we_p0 = 1'b1;
      end
      default: known_p0 = 1'b0;
    endcase
  end

  // ---- ID/EX boundary: rst > flush > stall > load; control bits gated by valid_i ----
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o    <= 1'b0;
      pc_o       <= '0;
      pc_plus4_o <= '0;
      rs1_o      <= '0;
      rs2_o      <= '0;
      rd_o       <= '0;
      rs1_data_o <= '0;
      rs2_data_o <= '0;
      imm_o      <= '0;
      alu_op_o   <= ALU_ADD;
      alu_src_o  <= 1'b0;
      reg_we_o   <= 1'b0;
      mem_re_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      branch_o   <= 1'b0;
      jump_o     <= 1'b0;
      wb_sel_o   <= WB_ALU;
      illegal_o  <= 1'b0;
    end else if (flush_i) begin
      valid_o    <= 1'b0;
      reg_we_o   <= 1'b0;
      mem_re_o   <= 1'b0;
      mem_we_o   <= 1'b0;
      branch_o   <= 1'b0;
      jump_o     <= 1'b0;
      illegal_o  <= 1'b0;
    end else if (!stall_i) begin
      valid_o    <= valid_i;
      pc_o       <= pc_i;
      pc_plus4_o <= pc_plus4_i;
      rs1_o      <= inst_i[19:15];
      rs2_o      <= inst_i[24:20];
      rd_o       <= inst_i[11:7];
      rs1_data_o <= rs1_data_p0;
      rs2_data_o <= rs2_data_p0;
      imm_o      <= imm_p0;
      alu_op_o   <= alu_op_p0;
      alu_src_o  <= alu_src_p0;
      wb_sel_o   <= wb_sel_p0;
      reg_we_o   <= valid_i && known_p0 && reg_we_p0;
      mem_re_o   <= valid_i && known_p0 && mem_re_p0;
      mem_we_o   <= valid_i && known_p0 && mem_we_p0;
      branch_o   <= valid_i && known_p0 && branch_p0;
      jump_o     <= valid_i && known_p0 && jump_p0;
      illegal_o  <= valid_i && !known_p0;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus queues expected ID/EX contents, a monitor
// pops and compares them one cycle after issue.
module tb_id_stage;

  localparam int M_VALID = 1;
  localparam int M_CTRL  = 2;
  localparam int M_DEC   = 4;
  localparam int M_IMM   = 8;
  localparam int M_PC    = 16;
  localparam int M_DATA  = 32;
  localparam int M_ALL   = 63;

  typedef struct {
    int          step;
    int          tgt;
    int          mask;
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_we, mem_re, mem_we, branch, jump, illegal;
    logic [1:0]  wb_sel;
    logic [31:0] pc, pc4, rs1d, rs2d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, valid_i, stall_i, flush_i, wb_we_i;
  logic [31:0] inst_i, pc_i, pc_plus4_i, wb_data_i;
  logic [4:0]  wb_rd_i;
  logic        valid_o, alu_src_o, reg_we_o, mem_re_o, mem_we_o, branch_o, jump_o, illegal_o;
  logic [31:0] pc_o, pc_plus4_o, rs1_data_o, rs2_data_o, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [3:0]  alu_op_o;
  logic [1:0]  wb_sel_o;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   step_n = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  exp_t e;

  id_stage #(.DATA_WIDTH(32), .REG_COUNT(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .inst_i(inst_i), .pc_i(pc_i),
    .pc_plus4_i(pc_plus4_i), .stall_i(stall_i), .flush_i(flush_i),
    .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .valid_o(valid_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
    .alu_op_o(alu_op_o), .alu_src_o(alu_src_o), .reg_we_o(reg_we_o),
    .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .branch_o(branch_o),
    .jump_o(jump_o), .wb_sel_o(wb_sel_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t blank(input int mask);
    exp_t x;
    x.step = 0; x.tgt = 0; x.mask = mask;
    x.valid = 0; x.rd = 0; x.imm = 0; x.alu_op = 0; x.alu_src = 0;
    x.reg_we = 0; x.mem_re = 0; x.mem_we = 0; x.branch = 0; x.jump = 0; x.illegal = 0;
    x.wb_sel = 0; x.pc = 0; x.pc4 = 0; x.rs1d = 0; x.rs2d = 0;
    return x;
  endfunction

  task automatic chk(input int s, input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL step%0d %s: got 0x%08h want 0x%08h", s, n, act, req);
    end
  endtask

  task automatic compare(input exp_t x);
    if ((x.mask & M_VALID) != 0) chk(x.step, "valid_o", {31'b0, valid_o}, {31'b0, x.valid});
    if ((x.mask & M_CTRL) != 0) begin
      chk(x.step, "reg_we_o",  {31'b0, reg_we_o},  {31'b0, x.reg_we});
      chk(x.step, "mem_re_o",  {31'b0, mem_re_o},  {31'b0, x.mem_re});
      chk(x.step, "mem_we_o",  {31'b0, mem_we_o},  {31'b0, x.mem_we});
      chk(x.step, "branch_o",  {31'b0, branch_o},  {31'b0, x.branch});
      chk(x.step, "jump_o",    {31'b0, jump_o},    {31'b0, x.jump});
      chk(x.step, "illegal_o", {31'b0, illegal_o}, {31'b0, x.illegal});
    end
    if ((x.mask & M_DEC) != 0) begin
      chk(x.step, "rd_o",      {27'b0, rd_o},      {27'b0, x.rd});
      chk(x.step, "alu_op_o",  {28'b0, alu_op_o},  {28'b0, x.alu_op});
      chk(x.step, "alu_src_o", {31'b0, alu_src_o}, {31'b0, x.alu_src});
      chk(x.step, "wb_sel_o",  {30'b0, wb_sel_o},  {30'b0, x.wb_sel});
    end
    if ((x.mask & M_IMM) != 0) chk(x.step, "imm_o", imm_o, x.imm);
    if ((x.mask & M_PC) != 0) begin
      chk(x.step, "pc_o", pc_o, x.pc);
      chk(x.step, "pc_plus4_o", pc_plus4_o, x.pc4);
    end
    if ((x.mask & M_DATA) != 0) begin
      chk(x.step, "rs1_data_o", rs1_data_o, x.rs1d);
      chk(x.step, "rs2_data_o", rs2_data_o, x.rs2d);
    end
  endtask

  // Monitor: compare every queued expectation on the cycle its result is due.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].tgt <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.tgt < cyc) begin
        total++;
        bad++;
        $display("FAIL step%0d missed: got cycle %0d want cycle %0d", mon_e.step, cyc, mon_e.tgt);
      end else begin
        compare(mon_e);
      end
    end
  end

  task automatic issue(input logic r, input logic v, input logic st, input logic fl,
                       input logic [31:0] ins, input logic [31:0] p,
                       input logic wwe, input logic [4:0] wrd, input logic [31:0] wd,
                       input exp_t x, input bit do_chk);
    @(negedge clk);
    rst = r; valid_i = v; stall_i = st; flush_i = fl;
    inst_i = ins; pc_i = p; pc_plus4_i = p + 32'd4;
    wb_we_i = wwe; wb_rd_i = wrd; wb_data_i = wd;
    if (do_chk) begin
      step_n++;
      x.step = step_n;
      x.tgt = cyc + 1;
      exp_q.push_back(x);
    end
  endtask

  initial begin
    rst = 1'b1; valid_i = 0; stall_i = 0; flush_i = 0; inst_i = 0; pc_i = 0;
    pc_plus4_i = 0; wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0;

    // 1: reset clears everything
    e = blank(M_ALL);
    issue(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, e, 1);

    // 2: addi x1,x0,5
    e = blank(M_ALL);
    e.valid = 1; e.rd = 1; e.imm = 5; e.alu_op = 0; e.alu_src = 1; e.reg_we = 1;
    e.pc = 32'h100; e.pc4 = 32'h104;
    issue(0, 1, 0, 0, 32'h00500093, 32'h100, 0, 0, 0, e, 1);

    // 3: add x4,x3,x3 with same-cycle write of x3 (bypass)
    e = blank(M_VALID | M_CTRL | M_DEC | M_PC | M_DATA);
    e.valid = 1; e.rd = 4; e.alu_op = 0; e.reg_we = 1; e.pc = 32'h104; e.pc4 = 32'h108;
    e.rs1d = 32'hDEADBEEF; e.rs2d = 32'hDEADBEEF;
    issue(0, 1, 0, 0, 32'h00318233, 32'h104, 1, 5'd3, 32'hDEADBEEF, e, 1);

    // 4: same read, now from the file
    e = blank(M_VALID | M_DATA);
    e.valid = 1; e.rs1d = 32'hDEADBEEF; e.rs2d = 32'hDEADBEEF;
    issue(0, 1, 0, 0, 32'h00318233, 32'h108, 0, 0, 0, e, 1);

    // 5: add x5,x0,x0 while writing 0x1234 to x0 (no bypass to x0)
    e = blank(M_VALID | M_DEC | M_DATA);
    e.valid = 1; e.rd = 5; e.alu_op = 0;
    issue(0, 1, 0, 0, 32'h000002B3, 32'h10C, 1, 5'd0, 32'h1234, e, 1);

    // 6: x0 still reads 0
    e = blank(M_VALID | M_DATA);
    e.valid = 1;
    issue(0, 1, 0, 0, 32'h000002B3, 32'h110, 0, 0, 0, e, 1);

    // 7: beq x0,x0,-4
    e = blank(M_VALID | M_CTRL | M_DEC | M_IMM | M_PC | M_DATA);
    e.valid = 1; e.branch = 1; e.rd = 5'd29; e.alu_op = 4'd1; e.imm = 32'hFFFFFFFC;
    e.pc = 32'h200; e.pc4 = 32'h204;
    issue(0, 1, 0, 0, 32'hFE000EE3, 32'h200, 0, 0, 0, e, 1);

    // 8: lw x6,8(x3)
    e = blank(M_ALL);
    e.valid = 1; e.rd = 6; e.imm = 8; e.alu_op = 0; e.alu_src = 1; e.reg_we = 1; e.mem_re = 1;
    e.wb_sel = 2'd1; e.pc = 32'h300; e.pc4 = 32'h304; e.rs1d = 32'hDEADBEEF; e.rs2d = 0;
    issue(0, 1, 0, 0, 32'h0081A303, 32'h300, 0, 0, 0, e, 1);

    // 9-10: stall twice, outputs hold (x3 written to 0x55 during the stall)
    issue(0, 1, 1, 0, 32'h0030A223, 32'h304, 1, 5'd3, 32'h55, e, 1);
    issue(0, 1, 1, 0, 32'h0030A223, 32'h308, 0, 0, 0, e, 1);

    // 11: stall+flush -> bubble; x7 written during the flush
    e = blank(M_VALID | M_CTRL);
    issue(0, 1, 1, 1, 32'h0030A223, 32'h308, 1, 5'd7, 32'h77, e, 1);

    // 12: sw x3,4(x1) sees the value written under stall
    e = blank(M_VALID | M_CTRL | M_DEC | M_IMM | M_PC | M_DATA);
    e.valid = 1; e.mem_we = 1; e.rd = 4; e.alu_op = 0; e.alu_src = 1; e.imm = 4;
    e.pc = 32'h308; e.pc4 = 32'h30C; e.rs1d = 0; e.rs2d = 32'h55;
    issue(0, 1, 0, 0, 32'h0030A223, 32'h308, 0, 0, 0, e, 1);

    // 13: add x8,x7,x0 sees the value written under flush
    e = blank(M_VALID | M_DATA);
    e.valid = 1; e.rs1d = 32'h77; e.rs2d = 0;
    issue(0, 1, 0, 0, 32'h00038433, 32'h30C, 0, 0, 0, e, 1);

    // 14: invalid slot with a jal: controls forced off
    e = blank(M_VALID | M_CTRL);
    issue(0, 0, 0, 0, 32'h000000EF, 32'h310, 0, 0, 0, e, 1);

    // 15: jal x1,8
    e = blank(M_VALID | M_CTRL | M_DEC | M_IMM | M_PC);
    e.valid = 1; e.jump = 1; e.reg_we = 1; e.rd = 1; e.alu_op = 0; e.alu_src = 1;
    e.wb_sel = 2'd2; e.imm = 8; e.pc = 32'h400; e.pc4 = 32'h404;
    issue(0, 1, 0, 0, 32'h008000EF, 32'h400, 0, 0, 0, e, 1);

    // 16: lui x2,0x12345
    e = blank(M_VALID | M_CTRL | M_DEC | M_IMM);
    e.valid = 1; e.reg_we = 1; e.rd = 2; e.alu_op = 4'd10; e.alu_src = 1; e.imm = 32'h12345000;
    issue(0, 1, 0, 0, 32'h12345137, 32'h404, 0, 0, 0, e, 1);

    // 17: all-zero word is illegal
    e = blank(M_VALID | M_CTRL);
    e.valid = 1; e.illegal = 1;
    issue(0, 1, 0, 0, 32'h00000000, 32'h408, 0, 0, 0, e, 1);

    // 18: reset during a stall wins on the same edge
    e = blank(M_ALL);
    issue(1, 1, 1, 0, 32'h00318233, 32'h40C, 0, 0, 0, e, 1);

    // 19: first load after reset; register file was cleared
    e = blank(M_VALID | M_PC | M_DATA);
    e.valid = 1; e.pc = 32'h500; e.pc4 = 32'h504; e.rs1d = 0; e.rs2d = 0;
    issue(0, 1, 0, 0, 32'h00318233, 32'h500, 0, 0, 0, e, 1);

    // drain the scoreboard with a bounded wait
    issue(0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, e, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter REG_COUNT, default 32, number of architectural registers.
REQ-003 SHALL have a single clock; reset is synchronous and active-high. Ports are listed below.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- valid_i  in  1  IF2 instruction valid.
- inst_i  in  32  instruction word from IF2.
- pc_i  in  32  PC of inst_i.
- pc_plus4_i  in  32  pc_i+4.
- stall_i  in  1  hold ID/EX register.
- flush_i  in  1  kill ID/EX contents (insert bubble).
- wb_we_i  in  1  WB register write enable.
- wb_rd_i  in  5  WB destination register.
- wb_data_i  in  32  WB write data.
- valid_o  out  1  ID/EX entry valid.
- pc_o, pc_plus4_o  out  32 each  registered PC values.
- rs1_o, rs2_o, rd_o  out  5 each  register indices.
- rs1_data_o, rs2_data_o  out  32 each  operand data.
- imm_o  out  32  sign-extended immediate.
- alu_op_o  out  4  alu_op_e.
- alu_src_o  out  1  0=rs2, 1=imm.
- reg_we_o, mem_re_o, mem_we_o, branch_o, jump_o  out  1 each  control bits.
- wb_sel_o  out  2  wb_sel_e (ALU, MEM, PC+4).
- illegal_o  out  1  unsupported opcode.

Function
REQ-004 SHALL decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP; any other opcode sets illegal_o=1 with reg_we_o=mem_we_o=mem_re_o=branch_o=jump_o=0.
REQ-005 SHALL form imm_o per I/S/B/U/J format: B and J have bit0=0; U is imm[31:12]<<12; all other formats sign-extend from inst_i[31].
REQ-006 SHALL contain a REG_COUNT x DATA_WIDTH register file: two combinational read ports, one write port written on clk when wb_we_i=1 and wb_rd_i!=0.
REQ-007 SHALL keep x0 reading as 0 at all times; writes to x0 are ignored.
REQ-008 SHALL bypass writes to reads: when wb_we_i=1, wb_rd_i!=0 and wb_rd_i equals rs1/rs2 in the same cycle, the read returns wb_data_i.
REQ-009 SHALL register all outputs in the ID/EX register; latency from inst_i to outputs is 1 cycle.
REQ-010 SHALL apply ID/EX update priority rst > flush_i > stall_i > load.
- flush: valid_o=0 and all control bits 0.
- stall: all outputs hold.
- load: capture decode results; valid_o=valid_i.
REQ-011 SHALL force all control bits to 0 in the loaded entry when valid_i=0.
REQ-012 SHALL continue register-file writes regardless of stall_i or flush_i.
REQ-013 SHALL, while stalled, not refresh rs1_data_o/rs2_data_o; the hazard unit handles the resulting staleness.

Reset
REQ-014 SHALL, on rst=1 at a clock edge, clear every ID/EX output to 0 (valid_o=0).
REQ-015 SHALL clear all register-file entries to 0 on reset.
REQ-016 SHALL make reset asserted mid-stall or mid-flush take effect on the same edge; the first load occurs on the edge after rst deasserts.

Structure
REQ-017 SHALL source opcode constants, alu_op_e, wb_sel_e and imm_type_e from the shared package riscv_pkg.
REQ-018 SHALL implement the register file as sub-module regfile, including its bypass; decode and the ID/EX register stay in id_stage.

Verification
REQ-019 SHALL cover: inst_i=0x00500093 (addi x1,x0,5), pc_i=0x100, valid_i=1 -> next cycle valid_o=1, rd_o=1, imm_o=5, alu_op_o=ADD, alu_src_o=1, reg_we_o=1, pc_o=0x100.
REQ-020 SHALL cover: wb_we_i=1, wb_rd_i=3, wb_data_i=0xDEADBEEF in the same cycle as inst_i=0x00318233 (add x4,x3,x3) -> rs1_data_o=rs2_data_o=0xDEADBEEF.
REQ-021 SHALL cover: a write of 0x1234 to x0, then a read of x0 -> rs1_data_o=0.
REQ-022 SHALL cover: inst_i=0xFE000EE3 (beq x0,x0,-4) -> imm_o=0xFFFFFFFC, branch_o=1, reg_we_o=0.
REQ-023 SHALL cover: stall_i=1 for 2 cycles -> outputs unchanged; then stall_i=1 with flush_i=1 -> valid_o=0 next cycle.
REQ-024 SHALL cover: inst_i=0x00000000 -> illegal_o=1, reg_we_o=0, mem_we_o=0; rst=1 mid-stream -> valid_o=0 and all register reads 0 after reset.
